// File: rtl/seg7_pkg.sv
// seg7_pkg: shared glyph constants and code-to-segment lookup
package seg7_pkg;
  localparam logic [3:0] CODE_MINUS = 4'd10;
  localparam logic [3:0] CODE_BLANK = 4'd15;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam int DP_BIT = 0;
  localparam logic [6:0] GLYPH_0 = 7'b0000001;
  localparam logic [6:0] GLYPH_1 = 7'b1001111;
  localparam logic [6:0] GLYPH_2 = 7'b0010010;
  localparam logic [6:0] GLYPH_3 = 7'b0000110;
  localparam logic [6:0] GLYPH_4 = 7'b1001100;
  localparam logic [6:0] GLYPH_5 = 7'b0100100;
  localparam logic [6:0] GLYPH_6 = 7'b0100000;
  localparam logic [6:0] GLYPH_7 = 7'b0001111;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0000100;
  localparam logic [6:0] GLYPH_MINUS = 7'b1111110;
  localparam logic [6:0] GLYPH_OFF = 7'b1111111;
  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      CODE_MINUS: glyph = GLYPH_MINUS;
      default: glyph = GLYPH_OFF;
    endcase
  endfunction
endpackage

// File: rtl/seg7_glyph_lut.sv
// seg7_glyph_lut: digit code, dot and suppress flag to active-low segment byte
module seg7_glyph_lut
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       dot,
  input  logic       suppress,
  output logic [7:0] seg
);
  always_comb begin
    seg = {glyph(code), 1'b1};
    seg[DP_BIT] = ~dot;
    seg = suppress ? SEG_BLANK : seg;
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment scanner with blanking and guard
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic                    blank_lz,
  input  logic                    load,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [PW-1:0] r_pre;
  logic [IW-1:0] r_idx;
  logic [4*NUM_DIGITS-1:0] r_dig;
  logic [NUM_DIGITS-1:0] r_dot;
  logic r_blz;
  logic [NUM_DIGITS-1:0] w_sup;
  logic w_run;
  logic [7:0] w_seg;
  logic w_guard;
  logic w_wrap;
  always_comb begin
    w_run = r_blz;
    w_sup = '0;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      w_run = w_run & (r_dig[4*i +: 4] == 4'd0) & ~r_dot[i];
      w_sup[i] = w_run;
    end
  end
  seg7_glyph_lut u_lut (
    .code    (r_dig[{r_idx, 2'b00} +: 4]),
    .dot     (r_dot[r_idx]),
    .suppress(w_sup[r_idx]),
    .seg     (w_seg)
  );
  assign w_guard = r_pre < PW'(GUARD_CYCLES);
  assign w_wrap = r_pre == PW'(REFRESH_DIV - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_dig <= '0;
      r_dot <= '0;
      r_blz <= 1'b0;
      seg <= SEG_BLANK;
      an <= '1;
    end else begin
      r_pre <= w_wrap ? '0 : r_pre + 1'b1;
      if (w_wrap) r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
      if (load) begin
        r_dig <= digits;
        r_dot <= dots;
        r_blz <= blank_lz;
      end
      seg <= w_guard ? SEG_BLANK : w_seg;
      an <= w_guard ? '1 : ~(NUM_DIGITS'(1) << r_idx);
    end
  end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard bench against a slot-arithmetic display model
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int RD = 4;
  localparam int G = 1;
  logic clk = 0;
  logic rst = 1;
  logic [4*N-1:0] digits = '0;
  logic [N-1:0] dots = '0;
  logic blank_lz = 0;
  logic load = 0;
  logic [7:0] seg;
  logic [N-1:0] an;
  int checks = 0;
  int passes = 0;
  int t = 0;
  logic [3:0] m_code [N];
  logic m_dot [N];
  logic m_blz = 0;
  logic [6:0] gl [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                          7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                          7'b0000000, 7'b0000100, 7'b1111110, 7'b1111111,
                          7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
  logic [7+N:0] q [$];
  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GUARD_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dots(dots),
    .blank_lz(blank_lz), .load(load), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  function automatic logic [7+N:0] expect_out();
    int d;
    bit sup;
    logic [N-1:0] a;
    if (t % RD < G) return {8'hFF, {N{1'b1}}};
    d = (t / RD) % N;
    sup = m_blz && d > 0;
    for (int j = d; j < N; j++) if (m_code[j] != 0 || m_dot[j]) sup = 0;
    a = '1;
    a[d] = 1'b0;
    return {sup ? 8'hFF : {gl[m_code[d]], ~m_dot[d]}, a};
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      q.push_back({8'hFF, {N{1'b1}}});
      t = 0;
      m_blz = 0;
      for (int j = 0; j < N; j++) begin
        m_code[j] = 0;
        m_dot[j] = 0;
      end
    end else begin
      q.push_back(expect_out());
      if (load) begin
        m_blz = blank_lz;
        for (int j = 0; j < N; j++) begin
          m_code[j] = digits[4*j +: 4];
          m_dot[j] = dots[j];
        end
      end
      t++;
    end
  end
  always @(negedge clk) begin
    logic [7+N:0] e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({seg, an} === e) passes++;
      else $display("FAIL out t=%0d: seg=%b an=%b expected seg=%b an=%b", $time, seg, an, e[7+N:N], e[N-1:0]);
    end
  end
  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p, input logic b);
    @(negedge clk);
    digits = d;
    dots = p;
    blank_lz = b;
    load = 1;
    @(negedge clk);
    load = 0;
  endtask
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    bit found;
    rst = 1;
    run(3);
    rst = 0;
    run(20);
    do_load(16'h1234, 4'b0000, 0);
    run(40);
    do_load(16'h0070, 4'b0000, 1);
    run(20);
    do_load(16'h0005, 4'b0100, 1);
    run(20);
    do_load(16'h00CA, 4'b0010, 0);
    run(20);
    do_load(16'h0000, 4'b0000, 1);
    run(20);
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (an == 4'b1011) found = 1;
    end
    checks++;
    if (found) passes++;
    else $display("FAIL wait_an1011: an=%b never reached required 1011", an);
    rst = 1;
    @(negedge clk);
    rst = 0;
    run(20);
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      @(negedge clk);
      if (t % (RD * N) == RD * N - 1) found = 1;
    end
    checks++;
    if (found) passes++;
    else $display("FAIL wait_wrap: slot wrap not reached, t=%0d required %0d", t % (RD * N), RD * N - 1);
    digits = 16'h8F97;
    dots = 4'b1001;
    blank_lz = 0;
    load = 1;
    @(negedge clk);
    load = 0;
    run(20);
    for (int k = 0; k < 40; k++) begin
      do_load({$urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)} & {4{4'hF}},
              N'($urandom), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 9) == 0) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
      end
      run($urandom_range(1, 20));
    end
    @(negedge clk);
    checks++;
    if (q.size() <= 1) passes++;
    else $display("FAIL drain: queue=%0d required <=1", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
